demle_zamanlayici: RTL and testbench



---
 rtl/demle_pkg.sv | 17 +
 rtl/demle_hesap.sv | 76 +++++++
 rtl/demle_zamanlayici.sv | 158 +++++++++++++++
 tb/tb_demle_zamanlayici.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demle_pkg.sv
// Shared definitions for the brew timer: FSM state encoding and the
// saturation ceiling used by the arithmetic pipeline.
package demle_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        HESAP = 2'd1,
        SAYIM = 2'd2,
        BITTI = 2'd3
    } durum_t;

    // All-ones value of a genislik-bit brew time (genislik <= 32).
    function automatic logic [31:0] SURE_MAX(input int unsigned genislik);
        return (32'd1 << genislik) - 32'd1;
    endfunction

endpackage

// File: rtl/demle_hesap.sv
// Brew-time arithmetic: (hedef - DERECE) * su + tane with saturation, carried
// through an HESAP_GECIKME-deep register chain together with valid/error bits.
module demle_hesap
    import demle_pkg::*;
#(
    parameter int DERECE        = 20,
    parameter int TANE_W        = 5,
    parameter int SU_W          = 8,
    parameter int SIC_W         = 7,
    parameter int SURE_W        = 15,
    parameter int HESAP_GECIKME = 3
) (
    input  logic              saat,
    input  logic              reset,
    input  logic              i_temizle,
    input  logic              i_gecerli,
    input  logic [TANE_W-1:0] i_tanecikler,
    input  logic [SU_W-1:0]   i_su_miktari,
    input  logic [SIC_W-1:0]  i_hedef_sicaklik,
    output logic              o_gecerli,
    output logic              o_hata,
    output logic [SURE_W-1:0] o_sonuc
);

    localparam int          CARP_W   = SIC_W + SU_W;
    localparam int          TOP_W    = ((CARP_W > TANE_W) ? CARP_W : TANE_W) + 1;
    localparam logic [31:0] DERECE_U = 32'(DERECE);

    logic [SIC_W-1:0]  w_fark;
    logic [CARP_W-1:0] w_carpim;
    logic [TOP_W-1:0]  w_toplam;
    logic              w_hata;
    logic [SURE_W-1:0] w_sonuc;

    logic [HESAP_GECIKME-1:0] r_gecerli;
    logic [HESAP_GECIKME-1:0] r_hata;
    logic [SURE_W-1:0]        r_sonuc [HESAP_GECIKME];

    // Raw brew time; the difference wraps for cold targets but w_hata discards it then.
    always_comb begin
        w_fark   = i_hedef_sicaklik - SIC_W'(DERECE);
        w_carpim = CARP_W'(w_fark) * CARP_W'(i_su_miktari);
        w_toplam = TOP_W'(w_carpim) + TOP_W'(i_tanecikler);
        w_hata   = (32'(i_hedef_sicaklik) <= DERECE_U);
        if (32'(w_toplam) > SURE_MAX(SURE_W)) begin
            w_sonuc = '1;
        end else begin
            w_sonuc = SURE_W'(w_toplam);
        end
    end

    // Delay chain; an abort flushes everything in flight.
    always_ff @(posedge saat) begin
        if (reset || i_temizle) begin
            r_gecerli <= '0;
            r_hata    <= '0;
            for (int i = 0; i < HESAP_GECIKME; i++) begin
                r_sonuc[i] <= '0;
            end
        end else begin
            r_gecerli[0] <= i_gecerli;
            r_hata[0]    <= w_hata;
            r_sonuc[0]   <= w_sonuc;
            for (int i = 1; i < HESAP_GECIKME; i++) begin
                r_gecerli[i] <= r_gecerli[i-1];
                r_hata[i]    <= r_hata[i-1];
                r_sonuc[i]   <= r_sonuc[i-1];
            end
        end
    end

    assign o_gecerli = r_gecerli[HESAP_GECIKME-1];
    assign o_hata    = r_hata[HESAP_GECIKME-1];
    assign o_sonuc   = r_sonuc[HESAP_GECIKME-1];

endmodule

// File: rtl/demle_zamanlayici.sv
// Brew timer top: accepts a request, waits for the computed brew time, counts
// it down in prescaled ticks and reports how the request ended.
module demle_zamanlayici
    import demle_pkg::*;
#(
    parameter int DERECE        = 20,
    parameter int TANE_W        = 5,
    parameter int SU_W          = 8,
    parameter int SIC_W         = 7,
    parameter int SURE_W        = 15,
    parameter int HESAP_GECIKME = 3,
    parameter int TIK_BOLEN     = 1
) (
    input  logic              saat,
    input  logic              reset,
    input  logic              basla,
    input  logic              iptal,
    input  logic [TANE_W-1:0] tanecikler,
    input  logic [SU_W-1:0]   su_miktari,
    input  logic [SIC_W-1:0]  hedef_sicaklik,
    output logic              hazir,
    output logic              mesgul,
    output logic [SURE_W-1:0] sure,
    output logic [SURE_W-1:0] kalan,
    output logic              bitti,
    output logic              demlendi,
    output logic              hata
);

    localparam int               BOL_W   = (TIK_BOLEN > 1) ? $clog2(TIK_BOLEN) : 1;
    localparam logic [BOL_W-1:0] BOL_SON = BOL_W'(TIK_BOLEN - 1);

    durum_t            r_durum;
    logic              r_hazir;
    logic              r_bitti;
    logic              r_demlendi;
    logic              r_hata;
    logic [SURE_W-1:0] r_sure;
    logic [SURE_W-1:0] r_kalan;
    logic [BOL_W-1:0]  r_bolen;

    logic              w_kabul;
    logic              w_temizle;
    logic              w_gecerli;
    logic              w_hata;
    logic [SURE_W-1:0] w_sonuc;

    assign w_kabul   = basla && r_hazir;
    assign w_temizle = iptal && ((r_durum == HESAP) || (r_durum == SAYIM));

    demle_hesap #(
        .DERECE        (DERECE),
        .TANE_W        (TANE_W),
        .SU_W          (SU_W),
        .SIC_W         (SIC_W),
        .SURE_W        (SURE_W),
        .HESAP_GECIKME (HESAP_GECIKME)
    ) u_hesap (
        .saat             (saat),
        .reset            (reset),
        .i_temizle        (w_temizle),
        .i_gecerli        (w_kabul),
        .i_tanecikler     (tanecikler),
        .i_su_miktari     (su_miktari),
        .i_hedef_sicaklik (hedef_sicaklik),
        .o_gecerli        (w_gecerli),
        .o_hata           (w_hata),
        .o_sonuc          (w_sonuc)
    );

    // Request FSM with prescaler and countdown; all outputs come from here.
    always_ff @(posedge saat) begin
        if (reset) begin
            r_durum    <= BOSTA;
            r_hazir    <= 1'b1;
            r_bitti    <= 1'b0;
            r_demlendi <= 1'b0;
            r_hata     <= 1'b0;
            r_sure     <= '0;
            r_kalan    <= '0;
            r_bolen    <= '0;
        end else begin
            r_bitti    <= 1'b0;
            r_demlendi <= 1'b0;
            r_hata     <= 1'b0;
            case (r_durum)
                BOSTA: begin
                    if (basla) begin
                        r_durum <= HESAP;
                        r_hazir <= 1'b0;
                    end
                end
                HESAP: begin
                    // An abort on the same edge as the result wins, so sure is not loaded.
                    if (iptal) begin
                        r_durum <= BITTI;
                        r_bitti <= 1'b1;
                        r_kalan <= '0;
                    end else if (w_gecerli) begin
                        if (w_hata) begin
                            r_sure  <= '0;
                            r_durum <= BITTI;
                            r_bitti <= 1'b1;
                            r_hata  <= 1'b1;
                        end else if (w_sonuc == '0) begin
                            r_sure     <= '0;
                            r_durum    <= BITTI;
                            r_bitti    <= 1'b1;
                            r_demlendi <= 1'b1;
                        end else begin
                            r_sure  <= w_sonuc;
                            r_kalan <= w_sonuc;
                            r_bolen <= '0;
                            r_durum <= SAYIM;
                        end
                    end
                end
                SAYIM: begin
                    if (iptal) begin
                        r_durum <= BITTI;
                        r_bitti <= 1'b1;
                        r_kalan <= '0;
                    end else if (r_bolen == BOL_SON) begin
                        r_bolen <= '0;
                        if (r_kalan <= SURE_W'(1)) begin
                            r_kalan    <= '0;
                            r_durum    <= BITTI;
                            r_bitti    <= 1'b1;
                            r_demlendi <= 1'b1;
                        end else begin
                            r_kalan <= r_kalan - SURE_W'(1);
                        end
                    end else begin
                        r_bolen <= r_bolen + BOL_W'(1);
                    end
                end
                BITTI: begin
                    r_durum <= BOSTA;
                    r_hazir <= 1'b1;
                end
                default: begin
                    r_durum <= BOSTA;
                    r_hazir <= 1'b1;
                    r_kalan <= '0;
                end
            endcase
        end
    end

    assign hazir    = r_hazir;
    assign mesgul   = ~r_hazir;
    assign sure     = r_sure;
    assign kalan    = r_kalan;
    assign bitti    = r_bitti;
    assign demlendi = r_demlendi;
    assign hata     = r_hata;

endmodule

// File: tb/tb_demle_zamanlayici.sv
// Self-checking bench: a timeline model of each request predicts every output
// on every cycle; literal checks pin the key timing points.
module tb_demle_zamanlayici;

    localparam int D  = 3;
    localparam int T  = 4;
    localparam int SW = 15;

    logic saat = 1'b0;
    initial forever #5 saat = ~saat;

    logic        reset, basla, iptal;
    logic [4:0]  tane;
    logic [7:0]  su;
    logic [6:0]  hedef;
    logic        hazir, mesgul, bitti, demlendi, hata;
    logic [14:0] sure, kalan;

    logic        s_basla, s_iptal;
    logic [4:0]  s_tane;
    logic [7:0]  s_su;
    logic [6:0]  s_hedef;
    logic        s_hazir, s_mesgul, s_bitti, s_demlendi, s_hata;
    logic [9:0]  s_sure, s_kalan;

    demle_zamanlayici #(.HESAP_GECIKME(D), .TIK_BOLEN(T)) u_dut (
        .saat(saat), .reset(reset), .basla(basla), .iptal(iptal),
        .tanecikler(tane), .su_miktari(su), .hedef_sicaklik(hedef),
        .hazir(hazir), .mesgul(mesgul), .sure(sure), .kalan(kalan),
        .bitti(bitti), .demlendi(demlendi), .hata(hata)
    );

    demle_zamanlayici #(.SURE_W(10), .HESAP_GECIKME(3), .TIK_BOLEN(1)) u_sat (
        .saat(saat), .reset(reset), .basla(s_basla), .iptal(s_iptal),
        .tanecikler(s_tane), .su_miktari(s_su), .hedef_sicaklik(s_hedef),
        .hazir(s_hazir), .mesgul(s_mesgul), .sure(s_sure), .kalan(s_kalan),
        .bitti(s_bitti), .demlendi(s_demlendi), .hata(s_hata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Request timeline model: each request is described by its start edge,
    // brew time, cause and optional abort edge.
    int n = 0;
    bit m_act = 1'b0, m_err, m_abt;
    int m_t0, m_S, m_a, m_old;
    int e_sure = 0, e_kalan = 0;
    bit e_hazir = 1'b1, e_bitti, e_dem, e_hata;
    bit chk_en = 1'b0;

    function automatic int brew(input int h, input int s, input int t, input int sw);
        int v, mx;
        v  = (h - 20) * s + t;
        mx = (1 << sw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int fin();
        int base;
        base = (m_err || m_S == 0) ? m_t0 + D : m_t0 + D + m_S * T;
        return m_abt ? m_a : base;
    endfunction

    initial begin
        forever begin
            @(posedge saat);
            n++;
            if (reset) begin
                m_act  = 1'b0;
                e_sure = 0;
            end else if (m_act && n <= fin() + 1) begin
                if (iptal && n <= fin() && !m_abt) begin
                    m_abt = 1'b1;
                    m_a   = n;
                end
            end else if (basla) begin
                m_act = 1'b1;
                m_t0  = n;
                m_abt = 1'b0;
                m_old = e_sure;
                m_err = (int'(hedef) <= 20);
                m_S   = m_err ? 0 : brew(int'(hedef), int'(su), int'(tane), SW);
            end
            if (m_act && n <= fin()) begin
                e_hazir = 1'b0;
                e_bitti = (n == fin());
                e_dem   = e_bitti && !m_abt && !m_err;
                e_hata  = e_bitti && !m_abt && m_err;
                e_kalan = (!m_err && m_S > 0 && n >= m_t0 + D && n < fin()) ?
                          m_S - (n - m_t0 - D) / T : 0;
                if (n >= m_t0 + D && !(m_abt && m_a <= m_t0 + D)) begin
                    e_sure = m_err ? 0 : m_S;
                end else begin
                    e_sure = m_old;
                end
            end else begin
                e_hazir = 1'b1;
                e_bitti = 1'b0;
                e_dem   = 1'b0;
                e_hata  = 1'b0;
                e_kalan = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge saat);
            if (chk_en) begin
                chk("m_hazir",    32'(hazir),    32'(e_hazir));
                chk("m_mesgul",   32'(mesgul),   32'(!e_hazir));
                chk("m_sure",     32'(sure),     32'(e_sure));
                chk("m_kalan",    32'(kalan),    32'(e_kalan));
                chk("m_bitti",    32'(bitti),    32'(e_bitti));
                chk("m_demlendi", 32'(demlendi), 32'(e_dem));
                chk("m_hata",     32'(hata),     32'(e_hata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bekle(input int k);
        repeat (k) @(negedge saat);
    endtask

    task automatic istek(input int h, input int s, input int t);
        hedef = 7'(h);
        su    = 8'(s);
        tane  = 5'(t);
        basla = 1'b1;
        @(negedge saat);
        basla = 1'b0;
    endtask

    task automatic bitti_bekle(input string nm, input int basl, input int beklenen);
        int at;
        at = basl;
        while (bitti !== 1'b1 && at < beklenen + 20) begin
            @(negedge saat);
            at++;
        end
        chk(nm, 32'(at), 32'(beklenen));
    endtask

    initial begin
        reset = 1'b1; basla = 1'b0; iptal = 1'b0;
        hedef = 7'd0; su = 8'd0; tane = 5'd0;
        s_basla = 1'b0; s_iptal = 1'b0; s_hedef = 7'd0; s_su = 8'd0; s_tane = 5'd0;
        bekle(2);
        chk_en = 1'b1;
        chk("rst_hazir", 32'(hazir), 32'd1);
        chk("rst_sure",  32'(sure),  32'd0);
        chk("rst_kalan", 32'(kalan), 32'd0);
        chk("rst_bitti", 32'(bitti), 32'd0);
        reset = 1'b0;
        bekle(1);

        // normal brew: 17 ticks of 4 cycles
        istek(25, 3, 2);
        bekle(3);
        chk("normal_sure",   32'(sure),  32'd17);
        chk("normal_kalan0", 32'(kalan), 32'd17);
        bekle(4);
        chk("normal_kalan1", 32'(kalan), 32'd16);
        bitti_bekle("normal_bitti_at", 7, 71);
        chk("normal_demlendi", 32'(demlendi), 32'd1);
        bekle(1);
        chk("normal_hazir", 32'(hazir), 32'd1);
        bekle(1);

        // cold target errors
        istek(20, 10, 5);
        bekle(2);
        chk("hata_erken", 32'(bitti), 32'd0);
        bekle(1);
        chk("hata_bitti",    32'(bitti),    32'd1);
        chk("hata_hata",     32'(hata),     32'd1);
        chk("hata_demlendi", 32'(demlendi), 32'd0);
        chk("hata_sure",     32'(sure),     32'd0);
        bekle(2);
        istek(19, 1, 1);
        bekle(3);
        chk("hata_19", 32'(hata), 32'd1);
        bekle(2);
        istek(21, 0, 1);
        bekle(3);
        chk("sinir_21_kalan", 32'(kalan), 32'd1);
        bitti_bekle("sinir_21_bitti_at", 3, 7);
        chk("sinir_21_hata",     32'(hata),     32'd0);
        chk("sinir_21_demlendi", 32'(demlendi), 32'd1);
        bekle(2);

        // zero brew time
        istek(90, 0, 0);
        bekle(2);
        chk("sifir_eski_sure", 32'(sure), 32'd1);
        bekle(1);
        chk("sifir_bitti",    32'(bitti),    32'd1);
        chk("sifir_demlendi", 32'(demlendi), 32'd1);
        chk("sifir_sure",     32'(sure),     32'd0);
        chk("sifir_kalan",    32'(kalan),    32'd0);
        bekle(2);

        // busy basla ignored, abort in countdown
        istek(25, 3, 2);
        bekle(7);
        hedef = 7'd90; su = 8'd200; tane = 5'd9; basla = 1'b1;
        bekle(1);
        basla = 1'b0;
        chk("mesgul_yoksay_sure", 32'(sure), 32'd17);
        bekle(4);
        iptal = 1'b1;
        bekle(1);
        iptal = 1'b0;
        chk("iptal_bitti",    32'(bitti),    32'd1);
        chk("iptal_demlendi", 32'(demlendi), 32'd0);
        chk("iptal_kalan",    32'(kalan),    32'd0);
        chk("iptal_sure",     32'(sure),     32'd17);
        bekle(1);
        chk("iptal_hazir", 32'(hazir), 32'd1);
        bekle(1);

        // abort during computation keeps previous sure
        istek(30, 2, 0);
        iptal = 1'b1;
        bekle(1);
        iptal = 1'b0;
        chk("hesap_iptal_bitti", 32'(bitti), 32'd1);
        chk("hesap_iptal_sure",  32'(sure),  32'd17);
        bekle(2);

        // abort beats completion on the final tick
        istek(21, 0, 1);
        bekle(6);
        iptal = 1'b1;
        bekle(1);
        iptal = 1'b0;
        chk("yaris_bitti",    32'(bitti),    32'd1);
        chk("yaris_demlendi", 32'(demlendi), 32'd0);
        chk("yaris_sure",     32'(sure),     32'd1);
        bekle(2);

        // basla and iptal together while idle
        hedef = 7'd25; su = 8'd1; tane = 5'd0;
        basla = 1'b1; iptal = 1'b1;
        bekle(1);
        basla = 1'b0; iptal = 1'b0;
        chk("bosta_iptal_kabul", 32'(hazir), 32'd0);
        bitti_bekle("bosta_iptal_bitti_at", 0, 23);
        chk("bosta_iptal_demlendi", 32'(demlendi), 32'd1);
        bekle(2);

        // reset mid-countdown, then a fresh normal request
        istek(25, 3, 2);
        bekle(10);
        reset = 1'b1;
        bekle(1);
        reset = 1'b0;
        chk("rst_orta_hazir", 32'(hazir), 32'd1);
        chk("rst_orta_kalan", 32'(kalan), 32'd0);
        chk("rst_orta_sure",  32'(sure),  32'd0);
        chk("rst_orta_bitti", 32'(bitti), 32'd0);
        bekle(1);
        chk("rst_orta_darbe_yok", 32'(bitti), 32'd0);
        istek(25, 3, 2);
        bekle(3);
        chk("taze_sure", 32'(sure), 32'd17);
        bitti_bekle("taze_bitti_at", 3, 71);
        chk("taze_demlendi", 32'(demlendi), 32'd1);
        bekle(1);
        chk("taze_hazir", 32'(hazir), 32'd1);

        // saturation on the 10-bit instance
        s_hedef = 7'd127; s_su = 8'd255; s_tane = 5'd31; s_basla = 1'b1;
        bekle(1);
        s_basla = 1'b0;
        bekle(3);
        chk("doyma_sure",   32'(s_sure),  32'd1023);
        chk("doyma_kalan0", 32'(s_kalan), 32'd1023);
        bekle(5);
        chk("doyma_kalan5", 32'(s_kalan), 32'd1018);
        s_iptal = 1'b1;
        bekle(1);
        s_iptal = 1'b0;
        chk("doyma_iptal_bitti", 32'(s_bitti), 32'd1);
        chk("doyma_iptal_sure",  32'(s_sure),  32'd1023);
        bekle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
